// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the PC, drives the instruction-memory address and
// loads the fetched word into the IR through run, branch-flush and halt states.
module fetch_sequencer #(
  parameter int                 A_BITS      = 8,
  parameter int                 IR_BITS     = 16,
  parameter logic [IR_BITS-1:0] HALT_WORD   = 16'hFFFF,
  parameter logic [IR_BITS-1:0] NOP_WORD    = 16'h0000,
  parameter int                 FLUSH_DEPTH = 2,
  parameter int                 CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IR_BITS-1:0]  imem_rdata_i,
  input  logic                stall_i,
  input  logic                br_take_i,
  input  logic [A_BITS-1:0]   br_target_i,
  input  logic                resume_i,
  output logic [A_BITS-1:0]   imem_addr_o,
  output logic [A_BITS-1:0]   pc_o,
  output logic [IR_BITS-1:0]  ir_o,
  output logic                ir_valid_o,
  output logic                flush_o,
  output logic                halted_o,
  output logic [CNT_BITS-1:0] issued_cnt_o
);

  // Counter must hold FLUSH_DEPTH; keep at least one bit when no bubbles are used.
  localparam int FC_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [A_BITS-1:0]   pc_q, pc_d;
  logic [IR_BITS-1:0]  ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    fcnt_d     = fcnt_q;
    cnt_d      = cnt_q;

    if (br_take_i) begin
      // A branch wins over every state action, including a pending resume.
      pc_d       = br_target_i;
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
      if (FLUSH_DEPTH > 0) begin
        state_d = FLUSH;
        fcnt_d  = FC_W'(FLUSH_DEPTH);
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (!stall_i) begin
            ir_d       = imem_rdata_i;
            ir_valid_d = 1'b1;
            if (imem_rdata_i != NOP_WORD) cnt_d = sat_inc(cnt_q);
            // PC stays on the HALT word so resume can step past it.
            if (imem_rdata_i == HALT_WORD) state_d = HALT;
            else                           pc_d    = pc_q + A_BITS'(1);
          end
        end
        FLUSH: begin
          ir_d       = NOP_WORD;
          ir_valid_d = 1'b0;
          fcnt_d     = (fcnt_q != '0) ? fcnt_q - FC_W'(1) : '0;
          if (fcnt_q <= FC_W'(1)) state_d = RUN;
        end
        HALT: begin
          ir_d       = NOP_WORD;
          ir_valid_d = 1'b0;
          if (resume_i) begin
            pc_d    = pc_q + A_BITS'(1);
            state_d = RUN;
          end
        end
        default: begin
          state_d    = RUN;
          ir_d       = NOP_WORD;
          ir_valid_d = 1'b0;
          fcnt_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      pc_q       <= '0;
      ir_q       <= NOP_WORD;
      ir_valid_q <= 1'b0;
      fcnt_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      fcnt_q     <= fcnt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign ir_valid_o   = ir_valid_q;
  assign flush_o      = br_take_i;
  assign halted_o     = (state_q == HALT);
  assign issued_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three configurations share one stimulus stream and
// are tracked by a bubble-count reference model, plus fixed vector tables.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  = 1'b0;
  logic        stall  = 1'b0;
  logic        br     = 1'b0;
  logic [7:0]  tgt    = 8'h00;
  logic        resume = 1'b0;
  logic [15:0] rom [256];

  // u0: defaults, u1: 2-bit counter, u2: no flush bubbles
  logic [7:0]  a0, a1, a2, pc0, pc1, pc2;
  logic [15:0] rd0, rd1, rd2, ir0, ir1, ir2, cnt0, cnt2;
  logic [1:0]  cnt1;
  logic        v0, v1, v2, f0, f1, f2, h0, h1, h2;

  assign rd0 = rom[a0];
  assign rd1 = rom[a1];
  assign rd2 = rom[a2];

  fetch_sequencer u0 (
    .clk(clk), .rst(rst_n), .imem_rdata_i(rd0), .stall_i(stall), .br_take_i(br),
    .br_target_i(tgt), .resume_i(resume), .imem_addr_o(a0), .pc_o(pc0), .ir_o(ir0),
    .ir_valid_o(v0), .flush_o(f0), .halted_o(h0), .issued_cnt_o(cnt0));

  fetch_sequencer #(.CNT_BITS(2)) u1 (
    .clk(clk), .rst(rst_n), .imem_rdata_i(rd1), .stall_i(stall), .br_take_i(br),
    .br_target_i(tgt), .resume_i(resume), .imem_addr_o(a1), .pc_o(pc1), .ir_o(ir1),
    .ir_valid_o(v1), .flush_o(f1), .halted_o(h1), .issued_cnt_o(cnt1));

  fetch_sequencer #(.FLUSH_DEPTH(0)) u2 (
    .clk(clk), .rst(rst_n), .imem_rdata_i(rd2), .stall_i(stall), .br_take_i(br),
    .br_target_i(tgt), .resume_i(resume), .imem_addr_o(a2), .pc_o(pc2), .ir_o(ir2),
    .ir_valid_o(v2), .flush_o(f2), .halted_o(h2), .issued_cnt_o(cnt2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got %0h, expected %0h (t=%0t)", k, nm, act, exp, $time);
  endtask

  // Reference model: a branch schedules a number of bubble edges; halted is a flag.
  int          depth [3] = '{2, 2, 0};
  int          cap   [3] = '{65535, 3, 65535};
  int          mpc [3], mbub [3], mcnt [3];
  logic [15:0] mir [3];
  bit          mv [3], mhalt [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mpc[k] = 0; mbub[k] = 0; mcnt[k] = 0; mir[k] = 16'h0000; mv[k] = 0; mhalt[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] w;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mpc[k] = 0; mbub[k] = 0; mcnt[k] = 0; mir[k] = 16'h0000; mv[k] = 0; mhalt[k] = 0;
      end else if (br) begin
        mpc[k] = int'(tgt); mir[k] = 16'h0000; mv[k] = 0; mhalt[k] = 0; mbub[k] = depth[k];
      end else if (mbub[k] > 0) begin
        mir[k] = 16'h0000; mv[k] = 0; mbub[k]--;
      end else if (mhalt[k]) begin
        mir[k] = 16'h0000; mv[k] = 0;
        if (resume) begin mpc[k] = (mpc[k] + 1) % 256; mhalt[k] = 0; end
      end else if (!stall) begin
        w = rom[mpc[k]];
        mir[k] = w; mv[k] = 1;
        if (w != 16'h0000 && mcnt[k] < cap[k]) mcnt[k]++;
        if (w == 16'hFFFF) mhalt[k] = 1;
        else mpc[k] = (mpc[k] + 1) % 256;
      end
    end
  endtask

  task automatic cmp_pre(input int k, input logic [7:0] addr, input logic fl);
    chk("imem_addr", k, 32'(addr), 32'(mpc[k]));
    chk("flush", k, 32'(fl), 32'(br));
  endtask

  task automatic cmp_post(input int k, input logic [7:0] pc, input logic [15:0] ir,
                          input logic v, input logic h, input logic [15:0] cnt);
    chk("pc", k, 32'(pc), 32'(mpc[k]));
    chk("ir", k, 32'(ir), 32'(mir[k]));
    chk("ir_valid", k, 32'(v), 32'(mv[k]));
    chk("halted", k, 32'(h), 32'(mhalt[k]));
    chk("issued_cnt", k, 32'(cnt), 32'(mcnt[k]));
  endtask

  // One clock edge with the inputs currently driven; all instances checked against the model.
  task automatic step();
    #1;
    cmp_pre(0, a0, f0); cmp_pre(1, a1, f1); cmp_pre(2, a2, f2);
    model_edge();
    @(posedge clk); #1;
    cmp_post(0, pc0, ir0, v0, h0, cnt0);
    cmp_post(1, pc1, ir1, v1, h1, {14'd0, cnt1});
    cmp_post(2, pc2, ir2, v2, h2, cnt2);
  endtask

  task automatic drive(input bit r, input bit s, input bit b, input logic [7:0] t, input bit res);
    rst_n = r; stall = s; br = b; tgt = t; resume = res;
  endtask

  task automatic run(input int n);
    drive(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect0(input string nm, input logic [7:0] pc, input logic [15:0] ir,
                         input bit v, input bit h, input int cnt);
    chk({nm, ".pc"}, 0, 32'(pc0), 32'(pc));
    chk({nm, ".ir"}, 0, 32'(ir0), 32'(ir));
    chk({nm, ".ir_valid"}, 0, 32'(v0), 32'(v));
    chk({nm, ".halted"}, 0, 32'(h0), 32'(h));
    chk({nm, ".cnt"}, 0, 32'(cnt0), 32'(cnt));
  endtask

  typedef struct {
    bit         r, s, b, res, fl;
    logic [7:0] t, pc;
    logic [15:0] ir;
    bit         v, h;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit b, logic [7:0] t, bit res, bit fl,
                              logic [7:0] pc, logic [15:0] ir, bit v, bit h, int cnt);
    vec_t x;
    x.r = r; x.s = s; x.b = b; x.t = t; x.res = res; x.fl = fl;
    x.pc = pc; x.ir = ir; x.v = v; x.h = h; x.cnt = cnt;
    return x;
  endfunction

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0100 + 16'(i);
    rom[9] = 16'hFFFF;

    tbl[0]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h01, 16'h0100, 1, 0, 1);
    tbl[2]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h02, 16'h0101, 1, 0, 2);
    tbl[3]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h03, 16'h0102, 1, 0, 3);
    tbl[4]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h04, 16'h0103, 1, 0, 4);
    tbl[5]  = mk(1, 1, 0, 8'h00, 0, 0, 8'h04, 16'h0103, 1, 0, 4);
    tbl[6]  = mk(1, 1, 0, 8'h00, 0, 0, 8'h04, 16'h0103, 1, 0, 4);
    tbl[7]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h05, 16'h0104, 1, 0, 5);
    tbl[8]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h06, 16'h0105, 1, 0, 6);
    tbl[9]  = mk(1, 0, 1, 8'h40, 0, 1, 8'h40, 16'h0000, 0, 0, 6);
    tbl[10] = mk(1, 0, 0, 8'h00, 0, 0, 8'h40, 16'h0000, 0, 0, 6);
    tbl[11] = mk(1, 1, 0, 8'h00, 0, 0, 8'h40, 16'h0000, 0, 0, 6);
    tbl[12] = mk(1, 0, 0, 8'h00, 0, 0, 8'h41, 16'h0140, 1, 0, 7);
    tbl[13] = mk(1, 0, 0, 8'h00, 0, 0, 8'h42, 16'h0141, 1, 0, 8);

    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Free run, stall, branch with bubbles
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].res);
      #1;
      chk($sformatf("tbl%0d.flush", i), 0, 32'(f0), 32'(tbl[i].fl));
      step();
      expect0($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].ir, tbl[i].v, tbl[i].h, tbl[i].cnt);
      chk($sformatf("tbl%0d.cnt_sat", i), 1, 32'(cnt1), 32'((tbl[i].cnt > 3) ? 3 : tbl[i].cnt));
    end

    // HALT entry, long hold with stall noise, resume, resume ignored in RUN
    drive(0, 0, 0, 8'h00, 0); step();
    run(9);
    expect0("pre_halt", 8'h09, 16'h0108, 1, 0, 9);
    step();
    expect0("halt_entry", 8'h09, 16'hFFFF, 1, 1, 10);
    for (int i = 0; i < 12; i++) begin
      drive(1, 1'($urandom_range(0, 1)), 0, 8'h00, 0);
      step();
      chk("halt_hold.pc", 0, 32'(pc0), 32'h09);
      chk("halt_hold.halted", 0, 32'(h0), 32'h1);
    end
    expect0("halt_nop", 8'h09, 16'h0000, 0, 1, 10);
    drive(1, 0, 0, 8'h00, 1); step();
    expect0("resume", 8'h0A, 16'h0000, 0, 0, 10);
    drive(1, 0, 0, 8'h00, 0); step();
    expect0("after_resume", 8'h0B, 16'h010A, 1, 0, 11);
    drive(1, 0, 0, 8'h00, 1); step();
    expect0("resume_in_run", 8'h0C, 16'h010B, 1, 0, 12);

    // Branch taken while halted, together with resume
    drive(0, 0, 0, 8'h00, 0); step();
    run(10);
    chk("halt2.halted", 0, 32'(h0), 32'h1);
    drive(1, 0, 1, 8'h20, 1); step();
    expect0("br_in_halt", 8'h20, 16'h0000, 0, 0, 10);
    run(2);
    expect0("br_in_halt_flush", 8'h20, 16'h0000, 0, 0, 10);
    step();
    expect0("br_in_halt_target", 8'h21, 16'h0120, 1, 0, 11);

    // PC wrap, then reset in the middle of a flush (branch also asserted)
    drive(1, 0, 1, 8'hFE, 0); step();
    run(2);
    step();
    expect0("wrap_fe", 8'hFF, 16'h01FE, 1, 0, 12);
    step();
    expect0("wrap_ff", 8'h00, 16'h01FF, 1, 0, 13);
    drive(1, 0, 1, 8'h30, 0); step();
    run(1);
    drive(0, 1, 1, 8'h77, 1); step();
    expect0("reset_mid_flush", 8'h00, 16'h0000, 0, 0, 0);
    chk("reset_mid_flush.cnt_sat", 1, 32'(cnt1), 32'h0);
    run(1);
    expect0("reset_then_run", 8'h01, 16'h0100, 1, 0, 1);

    // NOP words are loaded but not counted
    rom[8'h50] = 16'h0000; rom[8'h51] = 16'h0000; rom[8'h52] = 16'h0000; rom[8'h53] = 16'h1234;
    drive(0, 0, 0, 8'h00, 0); step();
    drive(1, 0, 1, 8'h50, 0); step();
    run(3);
    expect0("nop_fetch", 8'h51, 16'h0000, 1, 0, 0);
    run(2);
    chk("nop_fetch.cnt_sat", 1, 32'(cnt1), 32'h0);
    run(1);
    expect0("after_nops", 8'h54, 16'h1234, 1, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      rom[i] = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
    end
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0),
            8'($urandom),
            ($urandom_range(0, 9) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch stage of the Harvard pipeline. Owns the program counter, drives the instruction-memory address, and registers the fetched word into the IR.
- Sequences normal increment, hazard stalls, branch redirects (with bubble insertion and downstream flush), and HALT/resume.
- Sits between the instruction ROM and the decode stage. Takes stall and branch-resolve inputs from decode/execute.

Parameters:
- A_BITS, 8, PC / instruction-memory address width
- IR_BITS, 16, instruction word width
- HALT_WORD, 16'hFFFF, encoding that halts fetch
- NOP_WORD, 16'h0000, encoding presented on ir_o during bubbles
- FLUSH_DEPTH, 2, bubble cycles inserted after a taken branch (0 allowed)
- CNT_BITS, 16, issued-instruction counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- imem_rdata_i  in  IR_BITS  asynchronous-read data from instruction memory at imem_addr_o
- stall_i  in  1  hazard stall from decode; freeze PC and IR
- br_take_i  in  1  taken branch/jump resolved this cycle
- br_target_i  in  A_BITS  redirect address, valid with br_take_i
- resume_i  in  1  single-cycle pulse, leave HALT
- imem_addr_o  out  A_BITS  equals pc_o (combinational)
- pc_o  out  A_BITS  current PC register
- ir_o  out  IR_BITS  instruction register to decode
- ir_valid_o  out  1  ir_o holds a real fetched instruction
- flush_o  out  1  combinational, equals br_take_i; kills younger downstream instructions
- halted_o  out  1  high while in HALT state
- issued_cnt_o  out  CNT_BITS  count of non-NOP instructions loaded into IR, saturating

Behaviour:
- States: RUN, FLUSH, HALT. Reset (rst=0 at edge) forces:
  - state=RUN, pc=0, ir=NOP_WORD, ir_valid=0, flush counter=0, issued_cnt=0.
  - Reset overrides all other inputs.
- Per-edge priority: reset > br_take_i > state action.
- br_take_i (any state, including HALT and FLUSH):
  - pc<=br_target_i, ir<=NOP_WORD, ir_valid<=0.
  - If FLUSH_DEPTH>0: state<=FLUSH, counter<=FLUSH_DEPTH. Else state<=RUN.
  - A branch during FLUSH reloads the counter and retargets.
- RUN, stall_i=1: pc, ir and ir_valid hold.
- RUN, stall_i=0, imem_rdata_i==HALT_WORD:
  - ir<=HALT_WORD, ir_valid<=1, pc held, state<=HALT.
  - HALT_WORD is counted as issued.
- RUN, stall_i=0, other word:
  - ir<=imem_rdata_i, ir_valid<=1, pc<=pc+1.
  - PC wraps modulo 2^A_BITS, so 0xFF goes to 0x00.
- FLUSH:
  - ir<=NOP_WORD, ir_valid<=0, pc held, counter decrements; stall_i ignored.
  - When counter==1 at the edge, state<=RUN. Fetch at the target occurs on the following edge.
  - Net effect: the target instruction reaches ir_o FLUSH_DEPTH+1 edges after the branch edge.
- HALT:
  - halted_o=1, pc held, stall_i ignored.
  - The edge after entry loads ir<=NOP_WORD, ir_valid<=0.
  - resume_i=1: pc<=pc+1 (skip the HALT word), state<=RUN. The instruction after HALT is fetched on the next edge.
  - resume_i outside HALT is ignored. br_take_i together with resume_i: branch wins.
- Simultaneous stall_i and HALT word in RUN: stall wins; the HALT word is not loaded and HALT is not entered.
- issued_cnt increments on each edge where ir is loaded from imem_rdata_i with a word != NOP_WORD. It saturates at all-ones.
- Outputs pc_o, ir_o, ir_valid_o, halted_o and issued_cnt_o are registered. imem_addr_o and flush_o are combinational.

Test Plan:
- Reset then free-run, ROM[i]=0x0100+i, no stall:
  - pc_o = 1,2,3 on successive edges; ir_o = 0x0100,0x0101,... with ir_valid_o=1.
  - issued_cnt_o=3 after 3 edges.
- stall_i high 2 cycles at pc=4:
  - pc_o stays 4 and ir_o stays 0x0103 for both cycles.
  - Fetch resumes with 0x0104 on release; no count increment while stalled.
- br_take_i with target 0x40 at pc=6, FLUSH_DEPTH=2:
  - flush_o=1 that cycle; pc_o=0x40; ir_valid_o=0 for 3 edges.
  - ROM[0x40] appears on ir_o on the 3rd edge after the branch.
- ROM[9]=0xFFFF:
  - ir_o=0xFFFF, halted_o=1, pc_o holds 9 for 10+ cycles.
  - resume_i pulse gives pc_o=10, then ROM[10] loaded.
  - A second run with br_take_i asserted in HALT: exits to the target via FLUSH, halted_o=0.
- Wrap and reset: pc at 0xFF fetches, next pc_o=0x00. Assert rst=0 mid-FLUSH: all outputs at reset values next edge, state RUN.
- CNT_BITS=2: after 5 non-NOP fetches issued_cnt_o=3 (saturated); NOP_WORD fetches do not count.
